// File: rtl/ball_motion_if.sv
`default_nettype none
// ============================================================================
//  Module      : ball_motion_if
//  Description : Bundles the frame/control inputs, the paddle hitbox
//                rectangles and the ball/score outputs of ball_motion_ctrl.
//                slave  : the motion controller (consumes control/hitboxes)
//                master : the environment driving it (game logic or bench)
//  Signals     : frame_tick, start, pause       control pulses/levels
//                hb_x, hb_y, hb_right, hb_bottom packed hitboxes, idx 0 LSBs
//                ball_x, ball_y, ball_right, ball_bottom   ball rectangle
//                score_left, score_right         one-cycle point pulses
//                moving                          high while ball in play
//  Revision    : 1.0 - initial release
// ============================================================================
interface ball_motion_if #(
    parameter int X_W        = 10,
    parameter int Y_W        = 10,
    parameter int N_HITBOXES = 3
);
    logic                         frame_tick;
    logic                         start;
    logic                         pause;
    logic [N_HITBOXES*X_W-1:0]    hb_x;
    logic [N_HITBOXES*Y_W-1:0]    hb_y;
    logic [N_HITBOXES*X_W-1:0]    hb_right;
    logic [N_HITBOXES*Y_W-1:0]    hb_bottom;
    logic [X_W-1:0]               ball_x;
    logic [Y_W-1:0]               ball_y;
    logic [X_W-1:0]               ball_right;
    logic [Y_W-1:0]               ball_bottom;
    logic                         score_left;
    logic                         score_right;
    logic                         moving;

    modport slave (
        input  frame_tick, start, pause,
        input  hb_x, hb_y, hb_right, hb_bottom,
        output ball_x, ball_y, ball_right, ball_bottom,
        output score_left, score_right, moving
    );

    modport master (
        output frame_tick, start, pause,
        output hb_x, hb_y, hb_right, hb_bottom,
        input  ball_x, ball_y, ball_right, ball_bottom,
        input  score_left, score_right, moving
    );
endinterface
`default_nettype wire

// File: rtl/ball_motion_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : ball_motion_ctrl
//  Description : Pong-style ball controller. Serves the ball after a frame
//                countdown, advances it once per frame tick, bounces it off
//                the top/bottom walls and off paddle hitboxes, and reports
//                points when it leaves the field on the left or right.
//  Ports       : clk    system clock
//                rst_n  asynchronous active-low reset
//                bus    ball_motion_if.slave (control, hitboxes, ball, scores)
//  Revision    : 1.0 - initial release
// ============================================================================
module ball_motion_ctrl #(
    parameter int X_W          = 10,
    parameter int Y_W          = 10,
    parameter int SPEED_W      = 5,
    parameter int N_HITBOXES   = 3,
    parameter int H_RES        = 640,
    parameter int V_RES        = 480,
    parameter int BORDER       = 10,
    parameter int BALL_SIDE    = 10,
    parameter int INIT_SPEED   = 4,
    parameter int DEFLECT_X    = 4,
    parameter int DEFLECT_Y    = 1,
    parameter int SIDE_HIT_Y   = 5,
    parameter int SIDE_ZONE    = 12,
    parameter int SERVE_FRAMES = 60
) (
    input  logic         clk,
    input  logic         rst_n,
    ball_motion_if.slave bus
);
    localparam int XW1   = X_W + 1;
    localparam int YW1   = Y_W + 1;
    localparam int SM_W  = SPEED_W - 1;
    localparam int CNT_W = (SERVE_FRAMES < 2) ? 1 : $clog2(SERVE_FRAMES + 1);

    localparam logic [X_W-1:0]   c_X_CENTRE  = X_W'(H_RES / 2 - BALL_SIDE / 2);
    localparam logic [Y_W-1:0]   c_Y_CENTRE  = Y_W'(V_RES / 2 - BALL_SIDE / 2);
    localparam logic [Y_W-1:0]   c_Y_MIN     = Y_W'(BORDER);
    localparam logic [Y_W-1:0]   c_Y_MAX     = Y_W'(V_RES - BORDER - BALL_SIDE);
    localparam logic [XW1-1:0]   c_SIDE_X    = XW1'(BALL_SIDE);
    localparam logic [XW1-1:0]   c_HALF_X    = XW1'(BALL_SIDE / 2);
    localparam logic [XW1-1:0]   c_HRES      = XW1'(H_RES);
    localparam logic [YW1-1:0]   c_SIDE_Y    = YW1'(BALL_SIDE);
    localparam logic [YW1-1:0]   c_HALF_Y    = YW1'(BALL_SIDE / 2);
    localparam logic [YW1-1:0]   c_TOP       = YW1'(BORDER);
    localparam logic [YW1-1:0]   c_FLOOR     = YW1'(V_RES - BORDER);
    localparam logic [YW1-1:0]   c_ZONE      = YW1'(SIDE_ZONE);
    localparam logic [SM_W-1:0]  c_SPD_MAX   = '1;
    localparam logic [SM_W-1:0]  c_INIT_SPD  = SM_W'(INIT_SPEED);
    localparam logic [SM_W-1:0]  c_DEFL_Y    = SM_W'(DEFLECT_Y);
    localparam logic [SM_W-1:0]  c_SIDE_SPD  = SM_W'(SIDE_HIT_Y);
    localparam logic [CNT_W-1:0] c_SERVE_END = CNT_W'(SERVE_FRAMES);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SERVE  = 2'd1,
        S_MOVE   = 2'd2,
        S_SCORED = 2'd3
    } state_t;

    // Direction bits: 1 = +x (right) / +y (down).
    state_t            r_state,     w_state_nxt;
    logic [X_W-1:0]    r_x,         w_x_nxt;
    logic [Y_W-1:0]    r_y,         w_y_nxt;
    logic [SM_W-1:0]   r_spd_x,     w_spd_x_nxt;
    logic [SM_W-1:0]   r_spd_y,     w_spd_y_nxt;
    logic              r_dir_x,     w_dir_x_nxt;
    logic              r_dir_y,     w_dir_y_nxt;
    logic              r_serve_dir, w_serve_dir_nxt;
    logic [CNT_W-1:0]  r_cnt,       w_cnt_nxt;
    logic              r_score_l,   w_score_l_nxt;
    logic              r_score_r,   w_score_r_nxt;

    // ------------------------------------------------------------------
    // Widened motion arithmetic. Every comparison against the next
    // position is rearranged so that it only adds, never subtracts, which
    // keeps the result exact even when the ball would step past zero.
    // ------------------------------------------------------------------
    logic              w_tick;
    logic [XW1-1:0]    w_xw, w_sx, w_nx_fwd, w_nx_back, w_ball_cx;
    logic [YW1-1:0]    w_yw, w_sy, w_ny_fwd, w_ny_back, w_ball_cy;
    logic              w_top, w_bot, w_exit_l, w_exit_r;
    logic [Y_W-1:0]    w_y_adv;
    logic [SPEED_W:0]  w_spd_sum;
    logic [SM_W-1:0]   w_spd_x_hit;
    logic [YW1-1:0]    w_sel_cy, w_dy_abs;
    logic              w_hit;

    assign w_tick    = bus.frame_tick & ~bus.pause;
    assign w_xw      = {1'b0, r_x};
    assign w_sx      = XW1'(r_spd_x);
    assign w_nx_fwd  = w_xw + w_sx;
    assign w_nx_back = w_xw - w_sx;
    assign w_ball_cx = w_xw + c_HALF_X;
    assign w_yw      = {1'b0, r_y};
    assign w_sy      = YW1'(r_spd_y);
    assign w_ny_fwd  = w_yw + w_sy;
    assign w_ny_back = w_yw - w_sy;
    assign w_ball_cy = w_yw + c_HALF_Y;

    assign w_top = r_dir_y ? (w_ny_fwd < c_TOP) : (w_yw < c_TOP + w_sy);
    assign w_bot = r_dir_y ? (w_ny_fwd + c_SIDE_Y > c_FLOOR)
                           : (w_yw + c_SIDE_Y > c_FLOOR + w_sy);
    assign w_y_adv = w_top ? c_Y_MIN :
                     w_bot ? c_Y_MAX :
                     (r_dir_y ? Y_W'(w_ny_fwd) : Y_W'(w_ny_back));

    assign w_exit_l = ~r_dir_x & (w_xw <= w_sx);
    assign w_exit_r =  r_dir_x & (w_nx_fwd + c_SIDE_X >= c_HRES);

    // ------------------------------------------------------------------
    // Per-hitbox overlap of the next ball rectangle (strict on all edges),
    // qualified by the ball heading toward the hitbox centre.
    // ------------------------------------------------------------------
    logic [N_HITBOXES-1:0] w_hit_vec;
    logic [YW1-1:0]        w_hb_cy [N_HITBOXES];

    for (genvar k = 0; k < N_HITBOXES; k++) begin : g_hitbox
        logic [XW1-1:0] w_l, w_r, w_cx;
        logic [YW1-1:0] w_t, w_b;
        logic           w_ovl_x, w_ovl_y, w_toward;

        assign w_l = {1'b0, bus.hb_x[k*X_W +: X_W]};
        assign w_r = {1'b0, bus.hb_right[k*X_W +: X_W]};
        assign w_t = {1'b0, bus.hb_y[k*Y_W +: Y_W]};
        assign w_b = {1'b0, bus.hb_bottom[k*Y_W +: Y_W]};

        assign w_ovl_x = r_dir_x ? ((w_nx_fwd < w_r) && (w_nx_fwd + c_SIDE_X > w_l))
                                 : ((w_xw < w_r + w_sx) && (w_xw + c_SIDE_X > w_l + w_sx));
        assign w_ovl_y = r_dir_y ? ((w_ny_fwd < w_b) && (w_ny_fwd + c_SIDE_Y > w_t))
                                 : ((w_yw < w_b + w_sy) && (w_yw + c_SIDE_Y > w_t + w_sy));

        assign w_cx         = (w_l + w_r) >> 1;
        assign w_toward     = r_dir_x ? (w_ball_cx < w_cx) : (w_ball_cx > w_cx);
        assign w_hit_vec[k] = w_ovl_x & w_ovl_y & w_toward;
        assign w_hb_cy[k]   = (w_t + w_b) >> 1;
    end

    // Descending scan so the lowest-indexed hitbox is the one kept.
    always_comb begin
        w_hit    = 1'b0;
        w_sel_cy = '0;
        for (int k = N_HITBOXES - 1; k >= 0; k--) begin
            if (w_hit_vec[k]) begin
                w_hit    = 1'b1;
                w_sel_cy = w_hb_cy[k];
            end
        end
    end

    assign w_dy_abs    = (w_ball_cy > w_sel_cy) ? (w_ball_cy - w_sel_cy) : (w_sel_cy - w_ball_cy);
    assign w_spd_sum   = (SPEED_W+1)'(r_spd_x) + (SPEED_W+1)'(DEFLECT_X);
    assign w_spd_x_hit = (w_spd_sum > (SPEED_W+1)'(c_SPD_MAX)) ? c_SPD_MAX : SM_W'(w_spd_sum);

    // ------------------------------------------------------------------
    // Next-state / datapath logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt     = r_state;
        w_x_nxt         = r_x;
        w_y_nxt         = r_y;
        w_spd_x_nxt     = r_spd_x;
        w_spd_y_nxt     = r_spd_y;
        w_dir_x_nxt     = r_dir_x;
        w_dir_y_nxt     = r_dir_y;
        w_serve_dir_nxt = r_serve_dir;
        w_cnt_nxt       = r_cnt;
        w_score_l_nxt   = 1'b0;
        w_score_r_nxt   = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_x_nxt = c_X_CENTRE;
                w_y_nxt = c_Y_CENTRE;
                if (bus.start && !bus.pause) begin
                    w_state_nxt = S_SERVE;
                    w_cnt_nxt   = '0;
                end
            end

            S_SERVE: begin
                if (w_tick) begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                    if (r_cnt + CNT_W'(1) == c_SERVE_END) begin
                        w_state_nxt = S_MOVE;
                        w_spd_x_nxt = c_INIT_SPD;
                        w_spd_y_nxt = c_DEFL_Y;
                        w_dir_y_nxt = 1'b1;
                        w_dir_x_nxt = r_serve_dir;
                    end
                end
            end

            S_MOVE: begin
                if (w_tick) begin
                    // A paddle hit beats an exit; on an exit the ball is
                    // left where it is and recentred in SCORED.
                    if (!w_hit && w_exit_l) begin
                        w_state_nxt   = S_SCORED;
                        w_score_r_nxt = 1'b1;
                    end else if (!w_hit && w_exit_r) begin
                        w_state_nxt   = S_SCORED;
                        w_score_l_nxt = 1'b1;
                    end else begin
                        w_y_nxt = w_y_adv;
                        if (w_hit) begin
                            w_dir_x_nxt = ~r_dir_x;
                            w_spd_x_nxt = w_spd_x_hit;
                            w_spd_y_nxt = (w_dy_abs > c_ZONE) ? c_SIDE_SPD : c_DEFL_Y;
                            w_dir_y_nxt = (w_ball_cy < w_sel_cy) ? 1'b0 : 1'b1;
                        end else begin
                            w_x_nxt = r_dir_x ? X_W'(w_nx_fwd) : X_W'(w_nx_back);
                        end
                        // The wall owns the vertical direction when both fire.
                        if (w_top) begin
                            w_dir_y_nxt = 1'b1;
                        end else if (w_bot) begin
                            w_dir_y_nxt = 1'b0;
                        end
                    end
                end
            end

            S_SCORED: begin
                // Always a single cycle, even while paused, so the score
                // pulse can never be stretched. Serve toward the side that
                // conceded: a right-player point means the left side lost.
                w_x_nxt         = c_X_CENTRE;
                w_y_nxt         = c_Y_CENTRE;
                w_serve_dir_nxt = r_score_l;
                w_cnt_nxt       = '0;
                w_state_nxt     = S_SERVE;
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_x         <= c_X_CENTRE;
            r_y         <= c_Y_CENTRE;
            r_spd_x     <= '0;
            r_spd_y     <= '0;
            r_dir_x     <= 1'b1;
            r_dir_y     <= 1'b1;
            r_serve_dir <= 1'b1;
            r_cnt       <= '0;
            r_score_l   <= 1'b0;
            r_score_r   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_x         <= w_x_nxt;
            r_y         <= w_y_nxt;
            r_spd_x     <= w_spd_x_nxt;
            r_spd_y     <= w_spd_y_nxt;
            r_dir_x     <= w_dir_x_nxt;
            r_dir_y     <= w_dir_y_nxt;
            r_serve_dir <= w_serve_dir_nxt;
            r_cnt       <= w_cnt_nxt;
            r_score_l   <= w_score_l_nxt;
            r_score_r   <= w_score_r_nxt;
        end
    end

    assign bus.ball_x      = r_x;
    assign bus.ball_y      = r_y;
    assign bus.ball_right  = r_x + X_W'(BALL_SIDE);
    assign bus.ball_bottom = r_y + Y_W'(BALL_SIDE);
    assign bus.score_left  = r_score_l;
    assign bus.score_right = r_score_r;
    assign bus.moving      = (r_state == S_MOVE);

endmodule
`default_nettype wire

// File: tb/tb_ball_motion_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_ball_motion_ctrl
//  Description : Self-checking bench for ball_motion_ctrl. A reference model
//                of the game rules predicts the outputs after every clock;
//                predictions are queued and a monitor compares them.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ball_motion_ctrl;
    localparam int X_W = 10, Y_W = 10, SPEED_W = 5, NHB = 3;
    localparam int H_RES = 640, V_RES = 480, BORDER = 10, BS = 10;
    localparam int INIT_SPEED = 4, DEFLECT_X = 4, DEFLECT_Y = 1;
    localparam int SIDE_HIT_Y = 5, SIDE_ZONE = 12, SF = 2;
    localparam int SPD_MAX = (1 << (SPEED_W - 1)) - 1;
    localparam int CX = H_RES / 2 - BS / 2;
    localparam int CY = V_RES / 2 - BS / 2;
    localparam int N_CYC = 15000;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    ball_motion_if #(.X_W(X_W), .Y_W(Y_W), .N_HITBOXES(NHB)) bus ();

    ball_motion_ctrl #(
        .X_W(X_W), .Y_W(Y_W), .SPEED_W(SPEED_W), .N_HITBOXES(NHB),
        .H_RES(H_RES), .V_RES(V_RES), .BORDER(BORDER), .BALL_SIDE(BS),
        .INIT_SPEED(INIT_SPEED), .DEFLECT_X(DEFLECT_X), .DEFLECT_Y(DEFLECT_Y),
        .SIDE_HIT_Y(SIDE_HIT_Y), .SIDE_ZONE(SIDE_ZONE), .SERVE_FRAMES(SF)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // ---------------- reference model ----------------
    typedef enum int {P_IDLE, P_SERVE, P_MOVE, P_SCORED} phase_t;
    phase_t m_ph;
    int     mx, my, msx, msy, mcnt;
    bit     mdx, mdy, mserve, mnext_serve, msl, msr;
    int     hx[NHB], hy[NHB], hr[NHB], hb[NHB];

    typedef struct { int x; int y; bit mv; bit sl; bit sr; } exp_t;
    exp_t q[$];

    int total = 0;
    int bad   = 0;

    function automatic void m_reset();
        m_ph = P_IDLE; mx = CX; my = CY; msx = 0; msy = 0; mcnt = 0;
        mdx = 1; mdy = 1; mserve = 1; mnext_serve = 1; msl = 0; msr = 0;
    endfunction

    function automatic void m_move();
        int nx, ny, hit, bcx, bcy, hcx, hcy, d;
        bit ovl, toward;
        nx  = mdx ? mx + msx : mx - msx;
        ny  = mdy ? my + msy : my - msy;
        bcx = mx + BS / 2;
        bcy = my + BS / 2;
        hit = -1;
        for (int k = 0; k < NHB; k++) begin
            ovl    = (nx < hr[k]) && (nx + BS > hx[k]) && (ny < hb[k]) && (ny + BS > hy[k]);
            hcx    = (hx[k] + hr[k]) / 2;
            toward = mdx ? (bcx < hcx) : (bcx > hcx);
            if (hit < 0 && ovl && toward) hit = k;
        end
        if (hit < 0 && !mdx && mx <= msx) begin
            m_ph = P_SCORED; msr = 1; mnext_serve = 0;
            return;
        end
        if (hit < 0 && mdx && nx + BS >= H_RES) begin
            m_ph = P_SCORED; msl = 1; mnext_serve = 1;
            return;
        end
        if (hit >= 0) begin
            hcy = (hy[hit] + hb[hit]) / 2;
            d   = (bcy > hcy) ? bcy - hcy : hcy - bcy;
            mdx = !mdx;
            msx = (msx + DEFLECT_X > SPD_MAX) ? SPD_MAX : msx + DEFLECT_X;
            msy = (d > SIDE_ZONE) ? SIDE_HIT_Y : DEFLECT_Y;
            mdy = (bcy < hcy) ? 1'b0 : 1'b1;
        end else begin
            mx = nx;
        end
        if (ny < BORDER) begin
            my = BORDER; mdy = 1;
        end else if (ny + BS > V_RES - BORDER) begin
            my = V_RES - BORDER - BS; mdy = 0;
        end else begin
            my = ny;
        end
    endfunction

    function automatic void m_step(bit tk, bit st, bit ps);
        msl = 0; msr = 0;
        case (m_ph)
            P_IDLE: if (st && !ps) begin m_ph = P_SERVE; mcnt = 0; end
            P_SERVE: if (tk && !ps) begin
                mcnt++;
                if (mcnt == SF) begin
                    m_ph = P_MOVE; msx = INIT_SPEED; msy = DEFLECT_Y; mdy = 1; mdx = mserve;
                end
            end
            P_MOVE: if (tk && !ps) m_move();
            P_SCORED: begin
                mx = CX; my = CY; mserve = mnext_serve; mcnt = 0; m_ph = P_SERVE;
            end
        endcase
    endfunction

    function automatic void push_exp();
        exp_t e;
        e.x = mx; e.y = my; e.mv = (m_ph == P_MOVE); e.sl = msl; e.sr = msr;
        q.push_back(e);
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic drive_boxes();
        for (int k = 0; k < NHB; k++) begin
            bus.hb_x[k*X_W +: X_W]      = X_W'(hx[k]);
            bus.hb_right[k*X_W +: X_W]  = X_W'(hr[k]);
            bus.hb_y[k*Y_W +: Y_W]      = Y_W'(hy[k]);
            bus.hb_bottom[k*Y_W +: Y_W] = Y_W'(hb[k]);
        end
    endtask

    task automatic new_boxes();
        int h;
        hx[0] = $urandom_range(15, 30);   hr[0] = hx[0] + 10;
        hx[1] = $urandom_range(595, 615); hr[1] = hx[1] + 10;
        hx[2] = $urandom_range(100, 500); hr[2] = hx[2] + $urandom_range(5, 30);
        for (int k = 0; k < NHB; k++) begin
            h = (k < 2) ? $urandom_range(30, 120) : $urandom_range(5, 40);
            hy[k] = $urandom_range(10, 470 - h);
            hb[k] = hy[k] + h;
        end
        drive_boxes();
    endtask

    task automatic cycle(bit rs, bit tk, bit st, bit ps, bit nb);
        @(negedge clk);
        if (nb) new_boxes();
        bus.frame_tick = tk;
        bus.start      = st;
        bus.pause      = ps;
        rst_n          = rs;
        if (!rs) m_reset();
        else     m_step(tk, st, ps);
        push_exp();
    endtask

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_ball(string name, int ex, int ey, bit emv);
        chk({name, " x"}, 32'(bus.ball_x), 32'(ex));
        chk({name, " y"}, 32'(bus.ball_y), 32'(ey));
        chk({name, " right"}, 32'(bus.ball_right), 32'(ex + BS));
        chk({name, " bottom"}, 32'(bus.ball_bottom), 32'(ey + BS));
        chk({name, " moving"}, 32'(bus.moving), 32'(emv));
    endtask

    // ---------------- monitor ----------------
    initial begin
        exp_t e;
        logic [X_W-1:0] ex_r;
        logic [Y_W-1:0] ey_b;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e    = q.pop_front();
                ex_r = X_W'(e.x + BS);
                ey_b = Y_W'(e.y + BS);
                total++;
                if (bus.ball_x !== X_W'(e.x) || bus.ball_y !== Y_W'(e.y) ||
                    bus.ball_right !== ex_r || bus.ball_bottom !== ey_b ||
                    bus.moving !== e.mv || bus.score_left !== e.sl ||
                    bus.score_right !== e.sr) begin
                    bad++;
                    $display("FAIL scoreboard @%0t: got x=%0d y=%0d r=%0d b=%0d mv=%0b sl=%0b sr=%0b expected x=%0d y=%0d r=%0d b=%0d mv=%0b sl=%0b sr=%0b",
                             $time, bus.ball_x, bus.ball_y, bus.ball_right, bus.ball_bottom,
                             bus.moving, bus.score_left, bus.score_right,
                             e.x, e.y, e.x + BS, e.y + BS, e.mv, e.sl, e.sr);
                end
            end
        end
    end

    // ---------------- main sequence ----------------
    initial begin
        int pcnt;
        bit rs, tk, st, ps, nb;
        bus.frame_tick = 1'b0;
        bus.start      = 1'b0;
        bus.pause      = 1'b0;
        hx[0] = 20;  hr[0] = 30;  hy[0] = 200; hb[0] = 280;
        hx[1] = 610; hr[1] = 620; hy[1] = 215; hb[1] = 265;
        hx[2] = 300; hr[2] = 310; hy[2] = 20;  hb[2] = 30;
        drive_boxes();
        m_reset();

        // Reset state, visible immediately.
        cycle(0, 0, 0, 0, 0);
        #1 chk_ball("reset", CX, CY, 0);
        chk("reset score_left", 32'(bus.score_left), 0);
        chk("reset score_right", 32'(bus.score_right), 0);
        cycle(0, 0, 0, 0, 0);

        // A tick before start does nothing.
        cycle(1, 1, 0, 0, 0);
        @(posedge clk); #1 chk_ball("tick before start", CX, CY, 0);

        // Start, two serve ticks, then the first move.
        cycle(1, 0, 1, 0, 0);
        cycle(1, 1, 0, 0, 0);
        cycle(1, 0, 0, 0, 0);
        cycle(1, 1, 0, 0, 0);
        @(posedge clk); #1 chk_ball("serve done", CX, CY, 1);
        cycle(1, 1, 0, 0, 0);
        @(posedge clk); #1 chk_ball("first move", 319, 236, 1);

        // Pause freezes everything across three ticks.
        for (int i = 0; i < 3; i++) cycle(1, 1, 0, 1, 0);
        @(posedge clk); #1 chk_ball("paused", 319, 236, 1);

        // Reset while the ball is moving.
        cycle(1, 1, 0, 0, 0);
        cycle(1, 1, 0, 0, 0);
        cycle(0, 0, 0, 0, 0);
        #1 chk_ball("reset mid-move", CX, CY, 0);
        cycle(0, 0, 0, 0, 0);

        // Randomised play against the model.
        pcnt = 0;
        for (int i = 0; i < N_CYC; i++) begin
            rs = ($urandom_range(0, 4999) != 0);
            tk = ($urandom_range(0, 2) == 0);
            st = ($urandom_range(0, 9) == 0);
            nb = ($urandom_range(0, 99) == 0);
            if (pcnt > 0) begin
                pcnt--; ps = 1;
            end else if ($urandom_range(0, 59) == 0) begin
                pcnt = $urandom_range(1, 12); ps = 1;
            end else begin
                ps = 0;
            end
            cycle(rs, tk, st, ps, nb);
        end

        repeat (3) @(posedge clk);
        #2 chk("queue drained", 32'(q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/ball_motion_ctrl.md
BALL_MOTION_CTRL -- requirements
Module: ball_motion_ctrl

Interface
REQ-001 SHALL have parameter X_W, default 10, x coordinate width.
REQ-002 SHALL have parameter Y_W, default 10, y coordinate width.
REQ-003 SHALL have parameter SPEED_W, default 5, speed width: 1 direction bit plus SPEED_W-1 magnitude bits.
REQ-004 SHALL have parameter N_HITBOXES, default 3, number of paddle hitboxes checked.
REQ-005 SHALL have parameters H_RES 640, V_RES 480, BORDER 10, BALL_SIDE 10: geometry in pixels.
REQ-006 SHALL have parameters INIT_SPEED 4, DEFLECT_X 4, DEFLECT_Y 1, SIDE_HIT_Y 5, SIDE_ZONE 12: speed constants and off-centre hit threshold.
REQ-007 SHALL have parameter SERVE_FRAMES, default 60, number of frame ticks waited before a serve.
REQ-008 clk  input  1  system clock.
REQ-009 rst_n  input  1  asynchronous active-low reset.
REQ-010 frame_tick  input  1  one-cycle pulse per video frame.
REQ-011 start  input  1  leaves IDLE.
REQ-012 pause  input  1  freezes motion and counters while high.
REQ-013 hb_x, hb_y, hb_right, hb_bottom  input  N_HITBOXES*X_W / N_HITBOXES*Y_W  packed hitbox rectangles, index 0 in LSBs.
REQ-014 ball_x, ball_y, ball_right, ball_bottom  output  X_W/Y_W  registered ball rectangle.
REQ-015 score_left, score_right  output  1  one-cycle point pulses.
REQ-016 moving  output  1  high in MOVE state.

Function
REQ-017 SHALL implement FSM IDLE, SERVE, MOVE, SCORED.
REQ-018 IDLE: ball held centred at (H_RES/2-BALL_SIDE/2, V_RES/2-BALL_SIDE/2); start -> SERVE with the serve counter cleared.
REQ-019 SERVE: counter increments on each unpaused frame_tick; at SERVE_FRAMES -> MOVE with spd_x=INIT_SPEED, spd_y=DEFLECT_Y, dir_y down, dir_x=serve_dir.
REQ-020 MOVE: on each unpaused frame_tick, next position = position +/- speed per axis; registers update the cycle after the tick, one update per tick.
REQ-021 Top wall: if next y < BORDER, y clamps to BORDER and dir_y becomes down.
REQ-022 Bottom wall: if next y+BALL_SIDE > V_RES-BORDER, y clamps to V_RES-BORDER-BALL_SIDE and dir_y becomes up.
REQ-023 Hitbox: next rectangle overlapping hitbox k (strict inequality on all four edges) while dir_x points toward the hitbox centre counts as a hit; the lowest index wins; a hit while moving away SHALL be ignored.
REQ-024 On a hit: x is not advanced that frame, dir_x inverts, and spd_x = min(spd_x+DEFLECT_X, 2^(SPEED_W-1)-1) with saturating arithmetic.
REQ-025 On a hit: dir_y = up if ball centre y < hitbox centre y, else down.
REQ-026 On a hit: spd_y = SIDE_HIT_Y if |centre difference| > SIDE_ZONE, else DEFLECT_Y.
REQ-027 Wall and hitbox responses in the same tick SHALL both apply, each on its own axis.
REQ-028 Left exit (moving left and x <= spd_x) SHALL pulse score_right; right exit (moving right and next x+BALL_SIDE >= H_RES) SHALL pulse score_left; a hit takes priority over an exit in the same tick.
REQ-029 SCORED: lasts one cycle with the score pulse high, recentres the ball, sets serve_dir toward the conceding side, then -> SERVE.
REQ-030 pause: no position, speed, counter or state change; score pulses are never stretched.
REQ-031 All coordinate arithmetic SHALL be done one bit wider than X_W/Y_W so intermediate results never wrap.
REQ-032 ball_right = ball_x+BALL_SIDE and ball_bottom = ball_y+BALL_SIDE at all times.

Reset
REQ-033 rst_n low asynchronously forces IDLE, centred ball, speeds 0, serve_dir right (+x), counter 0, score pulses 0, moving 0, including mid-MOVE or mid-SCORED.
REQ-034 After release, the first frame_tick SHALL have no effect until start is seen.

Verification
REQ-035 Reset -> ball (315,235,325,245), IDLE, moving=0, scores 0.
REQ-036 start, SERVE_FRAMES=2, 2 ticks -> MOVE; next tick -> ball_x=319, ball_y=236.
REQ-037 y=12, dir up, spd_y=5, tick -> y=10, dir_y down.
REQ-038 Hitbox (610,215,620,265), ball x=597, y=235, moving right, spd_x 4, tick -> x=597, dir left, spd_x=8, spd_y=1, dir_y down.
REQ-039 x=2 moving left at spd_x 4, tick -> score_right pulses for exactly 1 cycle, ball recentred, SERVE, next serve moving left.
REQ-040 pause high across 3 ticks in MOVE -> all outputs unchanged; rst_n low mid-MOVE -> REQ-035 values immediately.
